// File: rtl/ir_transmitter.sv
// ir_transmitter: SIRC-style 12-bit IR frame serialiser.
// Sends the latched command REPEATS times, one frame per FRAME_CYCLES slot,
// on-off keyed onto a carrier that toggles every CARRIER_HALF clocks.
module ir_transmitter #(
  parameter int unsigned UNIT_CYCLES  = 16200,
  parameter int unsigned CARRIER_HALF = 338,
  parameter int unsigned FRAME_CYCLES = 1215000,
  parameter int unsigned REPEATS      = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        transmit,
  input  logic [11:0] command,
  output logic        ir_out,
  output logic        busy,
  output logic        done
);

  localparam int unsigned UW = $clog2(4 * UNIT_CYCLES + 1);
  localparam int unsigned CW = $clog2(CARRIER_HALF + 1);
  localparam int unsigned FW = 21;

  localparam logic [UW-1:0] START_LAST = UW'(4 * UNIT_CYCLES - 1);
  localparam logic [UW-1:0] ONE_LAST   = UW'(UNIT_CYCLES - 1);
  localparam logic [UW-1:0] TWO_LAST   = UW'(2 * UNIT_CYCLES - 1);
  localparam logic [CW-1:0] CAR_LAST   = CW'(CARRIER_HALF - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_CYCLES - 1);
  localparam logic [3:0]    LAST_REP   = 4'(REPEATS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START_MARK,
    BIT_SPACE,
    BIT_MARK,
    GAP
  } state_t;

  state_t        state_q, state_d;
  logic [UW-1:0] unit_cnt_q, unit_cnt_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic [CW-1:0] car_cnt_q, car_cnt_d;
  logic          carrier_q, carrier_d;
  logic [3:0]    bit_idx_q, bit_idx_d;
  logic [3:0]    frame_idx_q, frame_idx_d;
  logic [11:0]   cmd_q, cmd_d;
  logic          ir_out_q, ir_out_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          mark_d;
  logic [UW-1:0] bit_last;

  // State register and all counters; synchronous reset aborts any request.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      unit_cnt_q  <= '0;
      frame_cnt_q <= '0;
      car_cnt_q   <= '0;
      carrier_q   <= 1'b0;
      bit_idx_q   <= '0;
      frame_idx_q <= '0;
      cmd_q       <= '0;
      ir_out_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      unit_cnt_q  <= unit_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      car_cnt_q   <= car_cnt_d;
      carrier_q   <= carrier_d;
      bit_idx_q   <= bit_idx_d;
      frame_idx_q <= frame_idx_d;
      cmd_q       <= cmd_d;
      ir_out_q    <= ir_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state, counters and carrier; outputs are computed from the next
  // state so that the registered ir_out lines up with the cycle it describes.
  always_comb begin
    state_d     = state_q;
    unit_cnt_d  = unit_cnt_q + 1'b1;
    frame_cnt_d = frame_cnt_q + 1'b1;
    bit_idx_d   = bit_idx_q;
    frame_idx_d = frame_idx_q;
    cmd_d       = cmd_q;
    done_d      = 1'b0;
    bit_last    = cmd_q[bit_idx_q] ? TWO_LAST : ONE_LAST;

    if (car_cnt_q == CAR_LAST) begin
      car_cnt_d = '0;
      carrier_d = ~carrier_q;
    end else begin
      car_cnt_d = car_cnt_q + 1'b1;
      carrier_d = carrier_q;
    end

    case (state_q)
      IDLE: begin
        unit_cnt_d  = '0;
        frame_cnt_d = '0;
        car_cnt_d   = '0;
        carrier_d   = 1'b0;
        if (transmit) begin
          cmd_d       = command;
          frame_idx_d = '0;
          bit_idx_d   = '0;
          carrier_d   = 1'b1;
          state_d     = START_MARK;
        end
      end
      START_MARK: begin
        if (unit_cnt_q == START_LAST) begin
          unit_cnt_d = '0;
          bit_idx_d  = '0;
          state_d    = BIT_SPACE;
        end
      end
      BIT_SPACE: begin
        if (unit_cnt_q == ONE_LAST) begin
          unit_cnt_d = '0;
          state_d    = BIT_MARK;
        end
      end
      BIT_MARK: begin
        if (unit_cnt_q == bit_last) begin
          unit_cnt_d = '0;
          if (bit_idx_q == 4'd11) begin
            state_d = GAP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            state_d   = BIT_SPACE;
          end
        end
      end
      GAP: begin
        unit_cnt_d = '0;
        if (frame_cnt_q == FRAME_LAST) begin
          frame_cnt_d = '0;
          car_cnt_d   = '0;
          if (frame_idx_q == LAST_REP) begin
            carrier_d = 1'b0;
            done_d    = 1'b1;
            state_d   = IDLE;
          end else begin
            carrier_d   = 1'b1;
            frame_idx_d = frame_idx_q + 1'b1;
            state_d     = START_MARK;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    mark_d   = (state_d == START_MARK) || (state_d == BIT_MARK);
    ir_out_d = mark_d & carrier_d;
    busy_d   = (state_d != IDLE);
  end

  assign ir_out = ir_out_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_ir_transmitter.sv
// Directed bench for ir_transmitter with short protocol timing.
module tb_ir_transmitter;

  localparam int UNIT  = 10;
  localparam int HALF  = 2;
  localparam int FRAME = 500;
  localparam int REPS  = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        transmit = 1'b0;
  logic [11:0] command = '0;
  logic        ir_out, busy, done;

  int n_checks = 0;
  int n_errors = 0;

  ir_transmitter #(
    .UNIT_CYCLES (UNIT),
    .CARRIER_HALF(HALF),
    .FRAME_CYCLES(FRAME),
    .REPEATS     (REPS)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .transmit(transmit),
    .command (command),
    .ir_out  (ir_out),
    .busy    (busy),
    .done    (done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Mark envelope for in-frame offset t (0-based): 4-unit start mark, then
  // per bit (LSB first) one unit space and a 1- or 2-unit mark.
  function automatic bit exp_mark(input logic [11:0] cmd, input int t);
    int pos;
    int len;
    if (t < 4 * UNIT) return 1'b1;
    pos = 4 * UNIT;
    for (int i = 0; i < 12; i++) begin
      pos += UNIT;
      len = cmd[i] ? 2 * UNIT : UNIT;
      if (t >= pos && t < pos + len) return 1'b1;
      pos += len;
    end
    return 1'b0;
  endfunction

  function automatic bit exp_ir(input logic [11:0] cmd, input int t);
    return exp_mark(cmd, t) && ((t % (2 * HALF)) < HALF);
  endfunction

  // One request; cycle k counts from the cycle after the accepting edge.
  task automatic run_request(input logic [11:0] cmd, input int last_high,
                             input bit inject, input bit chain);
    int ir_mis, busy_mis, done_cnt, done_at, pulses, last_seen, max_k;
    logic prev_ir;
    bit e_ir;
    ir_mis = 0; busy_mis = 0; done_cnt = 0; done_at = 0;
    pulses = 0; last_seen = 0; prev_ir = 1'b0;
    max_k = chain ? FRAME * REPS + 1 : FRAME * REPS + 10;
    transmit = 1'b1;
    command  = cmd;
    @(posedge clock); #1;
    transmit = 1'b0;
    command  = 12'hABC;
    for (int k = 1; k <= max_k; k++) begin
      e_ir = (k <= FRAME * REPS) ? exp_ir(cmd, (k - 1) % FRAME) : 1'b0;
      if (ir_out !== e_ir) ir_mis++;
      if (busy !== (k <= FRAME * REPS)) busy_mis++;
      if (done === 1'b1) begin
        done_cnt++;
        done_at = k;
      end
      if (k <= 4 * UNIT && ir_out === 1'b1 && prev_ir === 1'b0) pulses++;
      if (k <= FRAME && ir_out === 1'b1) last_seen = k;
      prev_ir = ir_out;
      if (k == 1) check("first_cycle_ir", int'(ir_out), 1);
      transmit = (inject && k == 149);
      command  = (inject && k == 149) ? 12'h123 : 12'hABC;
      if (k < max_k) begin
        @(posedge clock); #1;
      end
    end
    transmit = 1'b0;
    check("ir_wave_mismatches", ir_mis, 0);
    check("busy_mismatches", busy_mis, 0);
    check("done_pulse_count", done_cnt, 1);
    check("done_cycle", done_at, FRAME * REPS + 1);
    check("start_mark_pulses", pulses, 10);
    check("last_high_cycle", last_seen, last_high);
  endtask

  initial begin
    int bad;
    repeat (3) @(posedge clock);
    #1;
    check("reset_ir_out", int'(ir_out), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clock); #1;
      if (ir_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    check("idle_outputs_quiet", bad, 0);

    run_request(12'h000, 278, 1'b0, 1'b0);
    run_request(12'hFFF, 398, 1'b0, 1'b0);
    run_request(12'h495, 330, 1'b0, 1'b0);
    run_request(12'h000, 278, 1'b1, 1'b0);

    // Abort mid-frame with reset.
    transmit = 1'b1;
    command  = 12'h000;
    @(posedge clock); #1;
    transmit = 1'b0;
    for (int k = 1; k < 60; k++) begin
      @(posedge clock); #1;
    end
    check("pre_abort_busy", int'(busy), 1);
    reset = 1'b1;
    @(posedge clock); #1;
    check("abort_ir_out", int'(ir_out), 0);
    check("abort_busy", int'(busy), 0);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (done !== 1'b0 || busy !== 1'b0 || ir_out !== 1'b0) bad++;
      @(posedge clock); #1;
    end
    check("post_abort_quiet", bad, 0);
    run_request(12'h495, 330, 1'b0, 1'b1);

    // A request raised in the done cycle is accepted.
    transmit = 1'b1;
    command  = 12'h000;
    @(posedge clock); #1;
    transmit = 1'b0;
    check("chain_busy", int'(busy), 1);
    check("chain_ir_out", int'(ir_out), 1);
    check("chain_done_low", int'(done), 0);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ir_transmitter.md
Name: ir_transmitter

Overview:
- Downstream of the main control FSM; consumes its one-cycle transmit_ir strobe and 12-bit move_command.
- Serialises the command as a SIRC-style 12-bit IR frame, on-off keyed on a 40 kHz carrier, to drive the IR LED that commands the rover.
- Frame is sent REPEATS times back-to-back, then done is reported.
- Timing is cycle-counted from the 27 MHz system clock.

Parameters:
- UNIT_CYCLES, 16200: clocks per 600 us protocol unit.
- CARRIER_HALF, 338: clocks per carrier half-period, giving ~40 kHz.
- FRAME_CYCLES, 1215000: clocks per frame slot (45 ms), measured from frame start.
- REPEATS, 3: frames sent per request, 1..15.

Ports:
- clock  input  1  system clock, 27 MHz
- reset  input  1  synchronous, active-high
- transmit  input  1  request strobe; sampled every cycle
- command  input  12  {address[11:7], command[6:0]}; latched on acceptance
- ir_out  output  1  modulated LED drive (registered)
- busy  output  1  high while a request is in progress
- done  output  1  one-cycle pulse at completion

Behaviour:
- One clock, synchronous active-high reset. Reset values: ir_out=0, busy=0, done=0, state=IDLE, all counters 0.
- Reset mid-frame aborts the request. ir_out goes low on the next edge. No done pulse is issued.
- Acceptance:
  - transmit=1 in IDLE at edge E0: command is latched, frame_idx=0, state=START_MARK, counters are cleared.
  - busy and mark go high from cycle E0+1.
  - transmit while busy is ignored; the latched command is not disturbed.
- Modulation:
  - ir_out = mark AND carrier, registered.
  - carrier toggles every CARRIER_HALF clocks while busy. It restarts high with phase 0 at the start of every frame.
- States (the unit counter counts clocks within a state; on exit it resets to 0):
  - IDLE: mark=0. Wait for transmit.
  - START_MARK: mark=1 for 4*UNIT_CYCLES. Then bit_idx=0 and go to BIT_SPACE.
  - BIT_SPACE: mark=0 for 1*UNIT_CYCLES. Then go to BIT_MARK.
  - BIT_MARK: mark=1 for 2*UNIT_CYCLES if command[bit_idx]=1, else 1*UNIT_CYCLES. Bits are sent LSB first. If bit_idx=11 go to GAP, else bit_idx+1 and go to BIT_SPACE.
  - GAP: mark=0 until the frame counter reaches FRAME_CYCLES (the frame counter counts from frame start, i.e. the first START_MARK cycle). Then:
    - If frame_idx=REPEATS-1, go to IDLE with busy=0 and done=1 for exactly one cycle.
    - Otherwise frame_idx+1 and start the next frame at START_MARK.
- Timing results:
  - Busy lasts exactly REPEATS*FRAME_CYCLES cycles (E0+1 .. E0+REPEATS*FRAME_CYCLES).
  - done is high in cycle E0+REPEATS*FRAME_CYCLES+1, the same cycle busy is first low.
  - A new transmit in that done cycle is accepted.
- Frame counter is 21 bits, with no wrap inside a frame.
- Worst-case frame is 40 units (24 ms) < FRAME_CYCLES, so GAP is always ≥1 cycle. Parameter sets violating this are unsupported.

Test Plan (bench params UNIT_CYCLES=10, CARRIER_HALF=2, FRAME_CYCLES=500, REPEATS=2):
- Reset then idle 100 cycles -> ir_out=0, busy=0, done=0 throughout.
- transmit with command=12'h000 at E0 -> mark envelope (derived from ir_out):
  - start mark cycles 1–40, 10 carrier pulses;
  - then 12 × (10 off, 10 on);
  - last mark ends cycle 280; low until 500;
  - frame 2 identical from 501; done pulse at cycle 1001, busy low at 1001.
- command=12'hFFF -> every bit mark is 20 cycles; last mark ends cycle 400; frame slot still 500; done at 1001.
- command=12'h495 -> decoded mark lengths, LSB first, give bits 1,0,1,0,1,0,0,1,0,0,1,0; both frames identical.
- Pulse transmit with command=12'h123 at cycle 150 during a 12'h000 request -> ignored; both frames carry 12'h000; exactly one done pulse.
- Assert reset at cycle 60 of a frame -> ir_out=0 and busy=0 from the next edge; no done. A transmit afterwards starts a clean frame with carrier phase 0.
